// File: rtl/canvas_renderer_pkg.sv
// Shared constants and types for the handwriting canvas renderer.
package canvas_renderer_pkg;

    // Canvas geometry: 28x28 cells, each drawn as an 8x8 pixel block.
    localparam int GRID       = 28;
    localparam int CELLS      = GRID * GRID;
    localparam int CELL_SHIFT = 3;
    localparam int CANVAS_PX  = GRID << CELL_SHIFT;

    // Last valid cell index, in address width.
    localparam logic [9:0] LAST_CELL = 10'(CELLS - 1);

    // Wipe sequencer states.
    typedef enum logic {
        IDLE = 1'b0,
        WIPE = 1'b1
    } wipe_state_t;

    // 12-bit colour, {R4, G4, B4}.
    typedef logic [11:0] color_t;

    // Cell index y*28 + x built from shifts so no multiplier is needed.
    // Result wraps in 10 bits; callers qualify out-of-grid coordinates.
    function automatic logic [9:0] cell_index(input logic [9:0] y, input logic [9:0] x);
        return (y << 4) + (y << 3) + (y << 2) + x;
    endfunction

endpackage

// File: rtl/canvas_renderer_mem.sv
// 784x1 canvas store: one write port, a pixel-strobe gated render read
// port and a free-running classifier read port. Reads are registered and
// return the pre-write value when the same cell is written in that clk.
module canvas_mem
    import canvas_renderer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we_i,
    input  logic [9:0] waddr_i,
    input  logic       wdata_i,
    input  logic       ren_i,
    input  logic [9:0] raddr_i,
    output logic       rdata_o,
    input  logic [9:0] caddr_i,
    output logic       cdata_o
);

    logic mem_q [0:CELLS-1];
    logic rdata_q;
    logic cdata_q;

    // Single write port; out-of-range addresses never reach the array.
    always_ff @(posedge clk) begin
        if (we_i && (waddr_i < 10'(CELLS))) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Render read: advances only on pixel strobes so it stays in step with S1.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 1'b0;
        end else if (ren_i) begin
            rdata_q <= (raddr_i < 10'(CELLS)) ? mem_q[raddr_i] : 1'b0;
        end
    end

    // Classifier read: registered every clk, addresses past the canvas read 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdata_q <= 1'b0;
        end else begin
            cdata_q <= (caddr_i < 10'(CELLS)) ? mem_q[caddr_i] : 1'b0;
        end
    end

    assign rdata_o = rdata_q;
    assign cdata_o = cdata_q;

endmodule

// File: rtl/canvas_renderer.sv
// Pixel-colour stage behind the VGA timing generator. Owns the canvas wipe
// sequencer, pen write arbitration and a two-stage render pipeline that maps
// screen coordinates onto the 28x28 canvas scaled x8.
module canvas_renderer
    import canvas_renderer_pkg::*;
#(
    parameter int     ORG_X  = 208,
    parameter int     ORG_Y  = 128,
    parameter color_t FG     = 12'hFFF,
    parameter color_t BG     = 12'h000,
    parameter color_t BORDER = 12'h0F0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pclk,
    input  logic        valid_in,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        pen_we,
    input  logic [4:0]  pen_x,
    input  logic [4:0]  pen_y,
    input  logic        clear,
    output logic        busy,
    input  logic [9:0]  rd_addr,
    output logic        rd_data,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out
);

    // Screen-space bounds of the grid and of the 2-pixel border around it.
    localparam logic [9:0] ORG_X10  = 10'(ORG_X);
    localparam logic [9:0] ORG_Y10  = 10'(ORG_Y);
    localparam logic [9:0] SPAN10   = 10'(CANVAS_PX);
    localparam logic [9:0] FRM_X_LO = 10'(ORG_X - 2);
    localparam logic [9:0] FRM_X_HI = 10'(ORG_X + CANVAS_PX + 1);
    localparam logic [9:0] FRM_Y_LO = 10'(ORG_Y - 2);
    localparam logic [9:0] FRM_Y_HI = 10'(ORG_Y + CANVAS_PX + 1);
    localparam logic [4:0] MAX_CELL = 5'(GRID - 1);

    // ---------------- wipe sequencer / write arbitration ----------------
    wipe_state_t state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        mem_we;
    logic [9:0]  mem_waddr;
    logic        mem_wdata;
    logic        pen_ok;

    assign pen_ok = pen_we && (pen_x <= MAX_CELL) && (pen_y <= MAX_CELL);

    // Reset lands in WIPE at cell 0 so the canvas is always blank afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WIPE;
            cnt_q   <= 10'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and the single write port: wipe owns it while busy,
    // otherwise clear beats a coincident pen write.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d = WIPE;
                    cnt_d   = 10'd0;
                end else if (pen_ok) begin
                    mem_we    = 1'b1;
                    mem_waddr = cell_index({5'd0, pen_y}, {5'd0, pen_x});
                    mem_wdata = 1'b1;
                end
            end
            WIPE: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = 1'b0;
                if (cnt_q == LAST_CELL) begin
                    state_d = IDLE;
                    cnt_d   = 10'd0;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            default: begin
                state_d = WIPE;
                cnt_d   = 10'd0;
            end
        endcase
    end

    assign busy = (state_q == WIPE);

    // ---------------- S1 address/flag decode ----------------
    logic [9:0] dx, dy;
    logic       in_grid_c, in_frame_c;
    logic [9:0] render_addr;

    assign dx = h_cnt - ORG_X10;
    assign dy = v_cnt - ORG_Y10;

    // Unsigned wrap makes coordinates left of / above the origin fail the
    // span test without a separate lower-bound compare.
    assign in_grid_c  = valid_in && (dx < SPAN10) && (dy < SPAN10);
    assign in_frame_c = valid_in
                     && (h_cnt >= FRM_X_LO) && (h_cnt <= FRM_X_HI)
                     && (v_cnt >= FRM_Y_LO) && (v_cnt <= FRM_Y_HI)
                     && !in_grid_c;
    assign render_addr = cell_index({3'd0, dy[9:CELL_SHIFT]}, {3'd0, dx[9:CELL_SHIFT]});

    logic render_cell;

    canvas_mem u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .ren_i   (pclk),
        .raddr_i (render_addr),
        .rdata_o (render_cell),
        .caddr_i (rd_addr),
        .cdata_o (rd_data)
    );

    logic s1_valid_q, s1_grid_q, s1_frame_q, s1_hs_q, s1_vs_q;

    // S1: capture region flags and syncs; the cell bit arrives from the
    // render read port on the same strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_grid_q  <= 1'b0;
            s1_frame_q <= 1'b0;
            s1_hs_q    <= 1'b1;
            s1_vs_q    <= 1'b1;
        end else if (pclk) begin
            s1_valid_q <= valid_in;
            s1_grid_q  <= in_grid_c;
            s1_frame_q <= in_frame_c;
            s1_hs_q    <= hsync_in;
            s1_vs_q    <= vsync_in;
        end
    end

    // ---------------- S2 colour select ----------------
    color_t color_c;

    // Blanking overrides everything; then set cell, then border.
    always_comb begin
        color_c = BG;
        if (!s1_valid_q) begin
            color_c = BG;
        end else if (s1_grid_q && render_cell) begin
            color_c = FG;
        end else if (s1_frame_q) begin
            color_c = BORDER;
        end
    end

    color_t rgb_q;
    logic   hs_q, vs_q;

    // S2: register colour together with the syncs so they stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= BG;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else if (pclk) begin
            rgb_q <= color_c;
            hs_q  <= s1_hs_q;
            vs_q  <= s1_vs_q;
        end
    end

    assign rgb       = rgb_q;
    assign hsync_out = hs_q;
    assign vsync_out = vs_q;

endmodule

// File: tb/tb_canvas_renderer.sv
// Scoreboard bench for canvas_renderer: stimulus pushes expected responses,
// a monitor pops and compares them as the DUT produces outputs.
module tb_canvas_renderer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pclk = 1'b0;
    logic        valid_in = 1'b0;
    logic [9:0]  h_cnt = 10'd0;
    logic [9:0]  v_cnt = 10'd0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic        pen_we = 1'b0;
    logic [4:0]  pen_x = 5'd0;
    logic [4:0]  pen_y = 5'd0;
    logic        clear = 1'b0;
    logic        busy;
    logic [9:0]  rd_addr = 10'd0;
    logic        rd_data;
    logic [11:0] rgb;
    logic        hsync_out;
    logic        vsync_out;

    canvas_renderer dut (
        .clk       (clk),
        .rst       (rst),
        .pclk      (pclk),
        .valid_in  (valid_in),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .pen_we    (pen_we),
        .pen_x     (pen_x),
        .pen_y     (pen_y),
        .clear     (clear),
        .busy      (busy),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rgb       (rgb),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          kind;   // 0: rd_data, 1: busy
        logic [11:0] val;
        logic        hs;
        logic        vs;
    } ent_t;

    ent_t rd_q[$];
    ent_t px_q[$];

    int total = 0;
    int bad   = 0;
    int clk_cnt  = 0;
    int strb_cnt = 0;
    bit exp_cells [0:783];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at clk %0d: got %0h expected %0h", name, clk_cnt, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    ent_t last_px;
    bit   last_valid = 0;

    always @(posedge clk) begin
        bit was_strobe;
        bit was_rst;
        ent_t e;
        clk_cnt++;
        was_strobe = pclk;
        was_rst    = rst;
        if (pclk) strb_cnt++;
        #1;
        while (rd_q.size() > 0 && rd_q[0].due <= clk_cnt) begin
            e = rd_q.pop_front();
            if (e.kind == 0) chk("rd_data", {31'd0, rd_data}, {31'd0, e.val[0]});
            else             chk("busy", {31'd0, busy}, {31'd0, e.val[0]});
        end
        if (was_rst) begin
            last_valid = 0;
        end else if (was_strobe) begin
            last_valid = 0;
            while (px_q.size() > 0 && px_q[0].due <= strb_cnt) begin
                e = px_q.pop_front();
                chk("rgb", {20'd0, rgb}, {20'd0, e.val});
                chk("hsync_out", {31'd0, hsync_out}, {31'd0, e.hs});
                chk("vsync_out", {31'd0, vsync_out}, {31'd0, e.vs});
                last_px    = e;
                last_valid = 1;
            end
        end else if (last_valid) begin
            chk("rgb_hold", {20'd0, rgb}, {20'd0, last_px.val});
            chk("hsync_hold", {31'd0, hsync_out}, {31'd0, last_px.hs});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic exp_busy(input logic b);
        ent_t e;
        e.due = clk_cnt + 1; e.kind = 1; e.val = {11'd0, b}; e.hs = 1'b0; e.vs = 1'b0;
        rd_q.push_back(e);
    endtask

    task automatic exp_rd(input logic b);
        ent_t e;
        e.due = clk_cnt + 1; e.kind = 0; e.val = {11'd0, b}; e.hs = 1'b0; e.vs = 1'b0;
        rd_q.push_back(e);
    endtask

    task automatic sweep();
        for (int a = 0; a < 786; a++) begin
            @(negedge clk);
            rd_addr = (a < 784) ? 10'(a) : 10'd1023;
            exp_rd((a < 784) ? exp_cells[a] : 1'b0);
        end
    endtask

    task automatic pen(input int x, input int y);
        @(negedge clk);
        pen_we = 1'b1; pen_x = 5'(x); pen_y = 5'(y);
        @(negedge clk);
        pen_we = 1'b0;
    endtask

    // One pixel strobe followed by a non-strobe clk carrying junk inputs.
    task automatic pix(input int h, input int v, input logic val, input logic hs,
                       input logic vs, input logic [11:0] exp);
        ent_t e;
        @(negedge clk);
        h_cnt = 10'(h); v_cnt = 10'(v); valid_in = val;
        hsync_in = hs; vsync_in = vs; pclk = 1'b1;
        e.due = strb_cnt + 2; e.kind = 0; e.val = exp; e.hs = hs; e.vs = vs;
        px_q.push_back(e);
        @(negedge clk);
        pclk = 1'b0; h_cnt = 10'd208; v_cnt = 10'd128; valid_in = 1'b1;
        hsync_in = ~hs; vsync_in = ~vs;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 784; i++) exp_cells[i] = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, got %0d pending expected 0", rd_q.size() + px_q.size());
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        clear_model();

        // Reset state and reset wipe length.
        repeat (3) @(negedge clk);
        chk("reset_rgb", {20'd0, rgb}, 32'h000);
        chk("reset_hsync", {31'd0, hsync_out}, 32'd1);
        chk("reset_vsync", {31'd0, vsync_out}, 32'd1);
        chk("reset_rd_data", {31'd0, rd_data}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        repeat (782) @(negedge clk);
        exp_busy(1'b1);
        @(negedge clk);
        exp_busy(1'b0);
        sweep();

        // Pen write (3,5) -> cell 143; same-clk read sees old value.
        @(negedge clk);
        pen_we = 1'b1; pen_x = 5'd3; pen_y = 5'd5; rd_addr = 10'd143;
        exp_rd(1'b0);
        @(negedge clk);
        pen_we = 1'b0; rd_addr = 10'd143;
        exp_rd(1'b1);
        exp_cells[143] = 1'b1;

        // Out-of-range pen writes are dropped.
        pen(28, 0);
        pen(0, 28);
        pen(31, 31);
        sweep();

        // Render mapping with cells (0,0) and (3,5) set.
        pen(0, 0);
        pen(0, 0);
        exp_cells[0] = 1'b1;
        pix(208, 128, 1'b1, 1'b1, 1'b1, 12'hFFF);
        pix(215, 135, 1'b1, 1'b0, 1'b1, 12'hFFF);
        pix(216, 128, 1'b1, 1'b1, 1'b0, 12'h000);
        pix(206, 130, 1'b1, 1'b0, 1'b0, 12'h0F0);
        pix(205, 130, 1'b1, 1'b1, 1'b1, 12'h000);
        pix(207, 127, 1'b1, 1'b1, 1'b0, 12'h0F0);
        pix(206, 126, 1'b1, 1'b0, 1'b1, 12'h0F0);
        pix(205, 126, 1'b1, 1'b1, 1'b1, 12'h000);
        pix(432, 130, 1'b1, 1'b0, 1'b1, 12'h0F0);
        pix(433, 130, 1'b1, 1'b1, 1'b0, 12'h0F0);
        pix(434, 130, 1'b1, 1'b1, 1'b1, 12'h000);
        pix(208, 353, 1'b1, 1'b0, 1'b0, 12'h0F0);
        pix(208, 354, 1'b1, 1'b1, 1'b1, 12'h000);
        pix(432, 352, 1'b1, 1'b1, 1'b0, 12'h0F0);
        pix(431, 351, 1'b1, 1'b0, 1'b1, 12'h000);
        pix(232, 168, 1'b1, 1'b1, 1'b1, 12'hFFF);
        pix(239, 175, 1'b1, 1'b0, 1'b0, 12'hFFF);
        pix(240, 168, 1'b1, 1'b1, 1'b1, 12'h000);
        pix(231, 168, 1'b1, 1'b0, 1'b1, 12'h000);
        pix(215, 136, 1'b1, 1'b1, 1'b0, 12'h000);
        pix(208, 128, 1'b0, 1'b0, 1'b0, 12'h000);
        pix(206, 130, 1'b0, 1'b1, 1'b0, 12'h000);
        pix(209, 129, 1'b1, 1'b1, 1'b1, 12'hFFF);
        pix(0, 0, 1'b0, 1'b1, 1'b1, 12'h000);
        // Two unchecked strobes drain the pipeline.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            valid_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; pclk = 1'b1;
            @(negedge clk);
            pclk = 1'b0;
        end

        // Collision: clear with pen(1,1), re-clear at +100, pen at +200.
        @(negedge clk);
        clear = 1'b1; pen_we = 1'b1; pen_x = 5'd1; pen_y = 5'd1;
        exp_busy(1'b1);
        @(negedge clk);
        clear = 1'b0; pen_we = 1'b0;
        repeat (99) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (99) @(negedge clk);
        pen_we = 1'b1; pen_x = 5'd2; pen_y = 5'd2;
        @(negedge clk);
        pen_we = 1'b0;
        repeat (582) @(negedge clk);
        exp_busy(1'b1);
        @(negedge clk);
        exp_busy(1'b0);
        clear_model();
        sweep();

        // Reset 300 clks into a wipe restarts it from cell 0.
        pen(4, 4);
        pen(27, 27);
        @(negedge clk);
        rd_addr = 10'd783;
        exp_rd(1'b1);
        @(negedge clk);
        clear = 1'b1;
        exp_busy(1'b1);
        @(negedge clk);
        clear = 1'b0;
        repeat (299) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (782) @(negedge clk);
        exp_busy(1'b1);
        @(negedge clk);
        exp_busy(1'b0);
        sweep();

        repeat (5) @(negedge clk);
        chk("drain_rd_q", rd_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/canvas_renderer.md
# canvas_renderer

Pixel-colour stage directly downstream of the VGA timing generator. It holds a 28×28 one-bit handwriting canvas, which the pen/input logic writes cell by cell. On each pixel strobe it maps the scanned coordinate onto the canvas, scaled ×8, and drives 12-bit RGB. Sync outputs are delay-matched to the colour, and a side read port lets the digit classifier fetch canvas cells.

## Interface
- ORG_X, 208: screen x of the canvas's left edge; must be ≥ 2.
- ORG_Y, 128: screen y of the canvas's top edge; must be ≥ 2.
- FG, 12'hFFF: colour of a set cell.
- BG, 12'h000: colour of a clear cell, outside the canvas, and during blanking.
- BORDER, 12'h0F0: colour of the 2-pixel frame around the canvas.
- clk  in  1  system clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- pclk  in  1  pixel strobe; the same enable that drives the timing generator.
- valid_in  in  1  active-video flag from the timing generator.
- h_cnt  in  10  pixel x, 0..639.
- v_cnt  in  10  line y, 0..479.
- hsync_in  in  1  active-low hsync, aligned with h_cnt.
- vsync_in  in  1  active-low vsync, aligned with v_cnt.
- pen_we  in  1  single-clk pulse that sets cell (pen_x, pen_y).
- pen_x  in  5  cell column, 0..27.
- pen_y  in  5  cell row, 0..27.
- clear  in  1  single-clk pulse that starts a canvas wipe.
- busy  out  1  high while a wipe is in progress.
- rd_addr  in  10  classifier cell index = row*28 + col.
- rd_data  out  1  cell value at rd_addr.
- rgb  out  12  pixel colour, {R4, G4, B4}.
- hsync_out  out  1  hsync_in delayed 2 pixel strobes.
- vsync_out  out  1  vsync_in delayed 2 pixel strobes.

## Operation
- **Canvas storage:** 784-bit array. Cell index = y*28 + x, computed as (y<<4)+(y<<3)+(y<<2)+x in 10 bits.
- **Pen writes:**
  - Applied when pen_we=1, busy=0, and pen_x ≤ 27 and pen_y ≤ 27.
  - Writes with pen_x or pen_y > 27 are dropped silently.
  - Setting an already-set cell is a no-op.
- **Wipe state machine:** IDLE → WIPE → IDLE.
  - In WIPE a 10-bit counter clears cell cnt once per clk (not gated by pclk), counting 0..783.
  - The machine leaves WIPE after clearing cell 783.
  - busy is asserted in WIPE.
  - clear in IDLE enters WIPE on the next clk. clear while in WIPE is ignored; the counter is not restarted.
  - clear and pen_we in the same cycle: clear wins and the pen write is dropped.
  - pen_we while busy=1: dropped.
- **Reset behaviour:** reset forces WIPE with the counter at 0, so the canvas is always blank after reset. Reset asserted mid-wipe restarts the wipe from 0.
- **Render pipeline:** two stages, advanced only on clk cycles where pclk=1.
  - S1 registers:
    - in_grid = valid_in, with h_cnt−ORG_X < 224 and v_cnt−ORG_Y < 224 (unsigned, 10-bit).
    - in_frame = valid_in, with h_cnt in [ORG_X−2, ORG_X+225] and v_cnt in [ORG_Y−2, ORG_Y+225], and not in_grid.
    - The cell index from gx=(h_cnt−ORG_X)>>3 and gy=(v_cnt−ORG_Y)>>3.
    - The syncs.
  - S2 registers:
    - rgb = FG if in_grid and the cell is set; BORDER if in_frame; otherwise BG.
    - The syncs.
- **Blanking:** rgb is BG whenever the S1 copy of valid_in is 0.
- **Render during a wipe:** reads the live array. Partially wiped content may show for one frame; this is acceptable.
- **Classifier port:** rd_data is registered every clk from rd_addr. rd_addr > 783 returns 0.

## Timing
- Reset values:
  - rgb = BG, hsync_out = 1, vsync_out = 1.
  - rd_data = 0.
  - busy = 1, held for the reset cycle plus 784 clks after rst falls.
  - All pipeline flags = 0.
- Render latency is exactly 2 pclk strobes from inputs to rgb/hsync_out/vsync_out. Colour and syncs stay mutually aligned.
- All pipeline outputs hold their values when pclk=0.
- A pen write in cycle t is visible on rd_data for a read issued in cycle t+1, i.e. rd_data updates at t+2.
- A wipe started by clear at t has busy=1 from t+1 to t+784 and busy=0 at t+785.
- Array read and write in the same clk: the read returns the old value.

## Structure
- Shared package holds:
  - GRID=28, CELLS=784, CELL_SHIFT=3, CANVAS_PX=224.
  - The wipe state encoding (IDLE, WIPE).
  - The 12-bit colour type.
- Natural sub-module: canvas_mem, holding the 784×1 array, one write port, one render read port and one classifier read port. The wipe FSM and the render pipeline stay in canvas_renderer.

## Test plan
- **Reset wipe:** reset, then count clks while busy=1. Required: exactly 784 clks after rst falls. Then every rd_addr 0..783 returns rd_data=0.
- **Pen write and readback:** pen_we with (3,5). Required: rd_addr=143 gives rd_data=1 two clks later. A write to (28,0) is dropped; all cells stay 0.
- **Render mapping:** set cell (0,0), run a frame. Required:
  - rgb=FFF for h 208..215, v 128..135.
  - h=216 gives 000.
  - h=206, v=130 gives 0F0.
  - h=205 gives 000.
  - Each of these appears 2 strobes after the matching h_cnt.
- **Sync alignment:** compare hsync_out against hsync_in delayed 2 strobes. Required: equal every cycle. rgb=000 whenever valid_in was 0 two strobes earlier.
- **Collision rules:**
  - clear and pen_we(1,1) in the same clk: busy rises and cell 29 ends at 0.
  - A second clear 100 clks into the wipe: busy still falls at t+785.
- **Reset mid-wipe:** assert rst 300 clks into a wipe. Required: busy stays 1 for 784 clks after rst falls, and the canvas ends fully cleared.
